// File: rtl/tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tile_sched
// Purpose  : Tile sequencer for the systolic array. Runs a programmed count
//            of output tiles through LOAD -> COMPUTE -> DRAIN, with a
//            per-phase watchdog.
// Revision : 1.0  initial release
// ============================================================================
module tile_sched #(
    parameter int MAC_SIZE       = 128,
    parameter int ADDR_OUT_WIDTH = 23,
    parameter int TILE_CNT_WIDTH = 8,
    parameter int WDOG_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [TILE_CNT_WIDTH-1:0] num_tiles,
    input  logic [ADDR_OUT_WIDTH-1:0] out_base,
    output logic                      load_req,
    input  logic                      load_ack,
    output logic                      comp_enb,
    input  logic                      done_finish,
    input  logic                      mem_write_enb,
    output logic [TILE_CNT_WIDTH-1:0] tile_idx,
    output logic [ADDR_OUT_WIDTH-1:0] tile_base,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout
);

    localparam int WORDS_PER_TILE = MAC_SIZE * MAC_SIZE / 2;
    localparam int c_WCNT_W       = (WORDS_PER_TILE > 1) ? $clog2(WORDS_PER_TILE) : 1;
    localparam logic [c_WCNT_W-1:0]       c_LAST_BEAT   = c_WCNT_W'(WORDS_PER_TILE - 1);
    localparam logic [ADDR_OUT_WIDTH-1:0] c_TILE_STRIDE = ADDR_OUT_WIDTH'(WORDS_PER_TILE);
    localparam logic [WDOG_WIDTH-1:0]     c_WDOG_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COMP  = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                      r_state;
    logic [TILE_CNT_WIDTH-1:0]   r_num_tiles;
    logic [c_WCNT_W-1:0]         r_wcnt;
    logic [WDOG_WIDTH-1:0]       r_wdog;

    logic                        w_active;
    logic [WDOG_WIDTH-1:0]       w_wdog_nxt;
    logic                        w_wdog_hit;

    // Watchdog only runs in phases that wait on an external agent.
    assign w_active   = (r_state == S_LOAD) || (r_state == S_COMP) || (r_state == S_DRAIN);
    assign w_wdog_nxt = r_wdog + 1'b1;
    assign w_wdog_hit = w_active && (w_wdog_nxt == c_WDOG_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_num_tiles <= '0;
            r_wcnt      <= '0;
            r_wdog      <= '0;
            load_req    <= 1'b0;
            comp_enb    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            tile_idx    <= '0;
            tile_base   <= '0;
        end else begin
            done <= 1'b0;
            if (w_wdog_hit) begin
                r_state     <= S_IDLE;
                r_wdog      <= '0;
                r_wcnt      <= '0;
                load_req    <= 1'b0;
                comp_enb    <= 1'b0;
                busy        <= 1'b0;
                err_timeout <= 1'b1;
                tile_idx    <= '0;
                tile_base   <= '0;
            end else begin
                r_wdog <= w_active ? w_wdog_nxt : '0;
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            err_timeout <= 1'b0;
                            if (num_tiles != '0) begin
                                r_num_tiles <= num_tiles;
                                tile_idx    <= '0;
                                tile_base   <= out_base;
                                busy        <= 1'b1;
                                load_req    <= 1'b1;
                                r_state     <= S_LOAD;
                            end else begin
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (load_ack) begin
                            load_req <= 1'b0;
                            comp_enb <= 1'b1;
                            r_wdog   <= '0;
                            r_state  <= S_COMP;
                        end
                    end
                    S_COMP: begin
                        if (done_finish) begin
                            comp_enb <= 1'b0;
                            r_wdog   <= '0;
                            r_state  <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (mem_write_enb) begin
                            r_wdog <= '0;
                            if (r_wcnt == c_LAST_BEAT) begin
                                r_wcnt  <= '0;
                                r_state <= S_NEXT;
                            end else begin
                                r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (tile_idx == r_num_tiles - TILE_CNT_WIDTH'(1)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Base address wraps modulo the address space.
                            tile_idx  <= tile_idx + 1'b1;
                            tile_base <= tile_base + c_TILE_STRIDE;
                            load_req  <= 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_sched
// Purpose  : Directed, table-driven check of tile_sched (MAC_SIZE=4, 4-bit
//            watchdog) plus hand sequences for multi-tile, timeout and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_tile_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_tiles;
    logic [22:0] out_base;
    logic        load_req;
    logic        load_ack;
    logic        comp_enb;
    logic        done_finish;
    logic        mem_write_enb;
    logic [7:0]  tile_idx;
    logic [22:0] tile_base;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int n_vec;
    int n_err;

    tile_sched #(
        .MAC_SIZE       (4),
        .ADDR_OUT_WIDTH (23),
        .TILE_CNT_WIDTH (8),
        .WDOG_WIDTH     (4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_tiles     (num_tiles),
        .out_base      (out_base),
        .load_req      (load_req),
        .load_ack      (load_ack),
        .comp_enb      (comp_enb),
        .done_finish   (done_finish),
        .mem_write_enb (mem_write_enb),
        .tile_idx      (tile_idx),
        .tile_base     (tile_base),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [7:0]  nt;
        logic [22:0] ob;
        logic        ack;
        logic        fin;
        logic        we;
        logic [4:0]  ctl;   // {load_req, comp_enb, busy, done, err_timeout}
        logic [7:0]  ti;
        logic [22:0] tb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic [7:0] nt, input logic [22:0] ob,
                                input logic ack, input logic fin, input logic we,
                                input logic [4:0] ctl, input logic [7:0] ti, input logic [22:0] tb);
        vec_t v;
        v.st = st; v.nt = nt; v.ob = ob; v.ack = ack; v.fin = fin; v.we = we;
        v.ctl = ctl; v.ti = ti; v.tb = tb;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_tiles(input int n, input logic [22:0] base);
        logic [22:0] exp_base;
        start = 1'b1; num_tiles = n[7:0]; out_base = base;
        tick();
        start = 1'b0;
        chk("start_err_clr", err_timeout, 0);
        for (int t = 0; t < n; t++) begin
            exp_base = base + 23'(8 * t);
            chk("tile_load_req", {load_req, comp_enb, busy}, 3'b101);
            chk("tile_idx", tile_idx, t[7:0]);
            chk("tile_base", tile_base, exp_base);
            tick(); tick();
            load_ack = 1'b1; tick(); load_ack = 1'b0;
            chk("ack_to_comp", {load_req, comp_enb}, 2'b01);
            tick(); tick();
            chk("comp_hold", comp_enb, 1);
            done_finish = 1'b1; tick(); done_finish = 1'b0;
            chk("comp_drop", comp_enb, 0);
            for (int b = 0; b < 8; b++) begin
                mem_write_enb = 1'b1; tick(); mem_write_enb = 1'b0;
                chk("drain_state", {busy, done, load_req, comp_enb}, 4'b1000);
                if (b == 3) begin
                    tick();
                    chk("drain_gap", {busy, done, load_req}, 3'b100);
                end
            end
            tick();
        end
        chk("done_pulse", {busy, done, load_req, comp_enb}, 4'b0100);
        tick();
        chk("done_clear", {busy, done}, 2'b00);
    endtask

    initial begin
        int cnt;
        int ndone;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; num_tiles = '0; out_base = '0;
        load_ack = 1'b0; done_finish = 1'b0; mem_write_enb = 1'b0;
        tick(); tick();
        chk("reset_in", {load_req, comp_enb, busy, done, err_timeout, tile_idx, tile_base}, 0);
        rst_n = 1'b1;
        tick();
        chk("reset_out", {load_req, comp_enb, busy, done, err_timeout, tile_idx, tile_base}, 0);

        // Single tile with stray inputs; then a zero-tile start and a start in DONE.
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5'b10100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5'b10100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b10100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 5'b01100, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 1, 5'b01100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5'b00100, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5'b00100, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 5'b00010, 0, 0));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; num_tiles = tbl[i].nt; out_base = tbl[i].ob;
            load_ack = tbl[i].ack; done_finish = tbl[i].fin; mem_write_enb = tbl[i].we;
            tick();
            chk($sformatf("vec%0d", i),
                {load_req, comp_enb, busy, done, err_timeout, tile_idx, tile_base},
                {tbl[i].ctl, tbl[i].ti, tbl[i].tb});
        end
        start = 1'b0; num_tiles = '0; out_base = '0;
        load_ack = 1'b0; done_finish = 1'b0; mem_write_enb = 1'b0;

        run_tiles(3, 23'd100);
        run_tiles(2, 23'h7FFFF8);

        // Withheld done_finish trips the watchdog after 15 COMP cycles.
        start = 1'b1; num_tiles = 8'd1; out_base = '0; tick(); start = 1'b0;
        load_ack = 1'b1; tick(); load_ack = 1'b0;
        cnt = 0; ndone = 0;
        for (int i = 0; i < 40 && comp_enb; i++) begin
            cnt++;
            if (done) ndone++;
            tick();
        end
        chk("wdog_comp_cycles", cnt, 15);
        chk("wdog_abort", {err_timeout, busy, done, load_req, comp_enb}, 5'b10000);
        tick();
        chk("wdog_sticky", {err_timeout, busy, done}, 3'b100);
        chk("wdog_no_done", ndone, 0);
        run_tiles(1, 23'd0);

        // Async reset mid-DRAIN must discard the partial beat count.
        start = 1'b1; num_tiles = 8'd1; out_base = '0; tick(); start = 1'b0;
        load_ack = 1'b1; tick(); load_ack = 1'b0;
        done_finish = 1'b1; tick(); done_finish = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_write_enb = 1'b1; tick(); mem_write_enb = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {load_req, comp_enb, busy, done, err_timeout}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {load_req, comp_enb, busy, done}, 0);
        run_tiles(1, 23'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
